// File: rtl/fpu_ctrl.sv
// Multi-cycle sequencer between decode and the combinational FPU datapath.
// Operands are held on the FPU inputs for a per-opcode latency, then the result is written back.
module fpu_ctrl #(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        double,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        ready,
    output logic [63:0] fpu_a,
    output logic [63:0] fpu_b,
    output logic [2:0]  fpu_op,
    output logic        fpu_double,
    input  logic [63:0] fpu_result,
    output logic [63:0] result,
    output logic        wr_en,
    output logic [4:0]  wr_rd,
    output logic        illegal
);

    localparam logic [2:0] FPU_ADD = 3'b000;
    localparam logic [2:0] FPU_SUB = 3'b001;
    localparam logic [2:0] FPU_MUL = 3'b010;
    localparam logic [2:0] FPU_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  count;
    logic [4:0]  rd_latched;
    logic        issue;
    logic        accept;
    logic        reject;

    function automatic logic op_legal(input logic [2:0] o);
        case (o)
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    // Counter preload is LAT-1 so that EXEC spans exactly LAT cycles.
    function automatic logic [7:0] lat_load(input logic [2:0] o);
        case (o)
            FPU_ADD, FPU_SUB: lat_load = 8'(LAT_ADD - 1);
            FPU_MUL:          lat_load = 8'(LAT_MUL - 1);
            FPU_DIV:          lat_load = 8'(LAT_DIV - 1);
            default:          lat_load = 8'd0;
        endcase
    endfunction

    assign ready = (state == IDLE) || (state == DONE);

    // Flush outranks start, so it blocks both acceptance and the illegal pulse.
    always_comb begin
        issue  = ready & start & ~flush;
        accept = issue & op_legal(op);
        reject = issue & ~op_legal(op);
    end

    // Sequencer state, held FPU operands, captured result and write-back strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            rd_latched <= 5'd0;
            fpu_a      <= 64'd0;
            fpu_b      <= 64'd0;
            fpu_op     <= 3'd0;
            fpu_double <= 1'b0;
            result     <= 64'd0;
            wr_en      <= 1'b0;
            wr_rd      <= 5'd0;
            illegal    <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            illegal <= reject;

            if (accept) begin
                fpu_a      <= a;
                fpu_b      <= b;
                fpu_op     <= op;
                fpu_double <= double;
                rd_latched <= rd;
                count      <= lat_load(op);
            end else begin
                fpu_a      <= fpu_a;
                fpu_b      <= fpu_b;
                fpu_op     <= fpu_op;
                fpu_double <= fpu_double;
                rd_latched <= rd_latched;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (count != 8'd0) begin
                        count <= count - 8'd1;
                        state <= EXEC;
                    end else begin
                        result <= fpu_result;
                        wr_en  <= 1'b1;
                        wr_rd  <= rd_latched;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // The write-back already happened this cycle; flush only blocks a new issue.
                    if (accept) begin
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_ctrl.sv
// Self-checking bench for fpu_ctrl: directed scenarios plus random traffic against a
// cycle-number-based reference model and a behavioural stand-in for the FPU datapath.
module tb_fpu_ctrl;

    localparam int LAT_ADD = 1;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 12;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        double = 1'b0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        ready;
    logic [63:0] fpu_a;
    logic [63:0] fpu_b;
    logic [2:0]  fpu_op;
    logic        fpu_double;
    logic [63:0] fpu_result;
    logic [63:0] result;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic        illegal;

    fpu_ctrl #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .double(double),
        .a(a), .b(b), .rd(rd), .flush(flush), .ready(ready),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_double(fpu_double),
        .fpu_result(fpu_result), .result(result), .wr_en(wr_en), .wr_rd(wr_rd),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sp_to_dp(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'd0) return {s[31], 63'd0};
        if (s[30:23] == 8'hFF) return {s[31], 11'h7FF, 52'd0};
        e = {3'd0, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp_to_sp(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:52] < 11'd897) return {d[63], 31'd0};
        if (d[62:52] > 11'd1150) return {d[63], 8'hFF, 23'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Stand-in FPU; in single mode the upper word is junk so any masking is visible.
    function automatic logic [63:0] fpu_model(input logic [63:0] x, input logic [63:0] y,
                                              input logic [2:0] o, input logic dbl);
        real rx, ry, rr;
        rx = dbl ? $bitstoreal(x) : $bitstoreal(sp_to_dp(x[31:0]));
        ry = dbl ? $bitstoreal(y) : $bitstoreal(sp_to_dp(y[31:0]));
        case (o)
            OP_ADD:  rr = rx + ry;
            OP_SUB:  rr = rx - ry;
            OP_MUL:  rr = rx * ry;
            OP_DIV:  rr = rx / ry;
            default: rr = 0.0;
        endcase
        if (dbl) return $realtobits(rr);
        return {x[63:32] ^ y[63:32], dp_to_sp($realtobits(rr))};
    endfunction

    assign fpu_result = fpu_model(fpu_a, fpu_b, fpu_op, fpu_double);

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit          inflight;
    int          wb_cycle;
    int          illegal_cycle;
    logic [63:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic        m_dbl;
    logic [4:0]  m_rd;

    function automatic int lat_of(input logic [2:0] o);
        if (o == OP_MUL) return LAT_MUL;
        if (o == OP_DIV) return LAT_DIV;
        return LAT_ADD;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        inflight = 1'b0;
        wb_cycle = -1;
        illegal_cycle = -1;
        m_a = 64'd0;
        m_b = 64'd0;
        m_res = 64'd0;
        m_op = 3'd0;
        m_dbl = 1'b0;
        m_rd = 5'd0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit exp_ready, exp_wr;
        @(negedge clk);
        exp_ready = !inflight || (cyc == wb_cycle);
        exp_wr = inflight && (cyc == wb_cycle);
        chk("ready", 64'(ready), 64'(exp_ready));
        chk("wr_en", 64'(wr_en), 64'(exp_wr));
        chk("illegal", 64'(illegal), 64'(cyc == illegal_cycle));
        chk("result", result, m_res);
        chk("fpu_a", fpu_a, m_a);
        chk("fpu_b", fpu_b, m_b);
        chk("fpu_op", 64'(fpu_op), 64'(m_op));
        chk("fpu_double", 64'(fpu_double), 64'(m_dbl));
        if (exp_wr) chk("wr_rd", 64'(wr_rd), 64'(m_rd));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (inflight && cyc < wb_cycle) begin
                if (flush) inflight = 1'b0;
                else if (cyc == wb_cycle - 1) m_res = fpu_model(m_a, m_b, m_op, m_dbl);
            end else if (inflight && cyc == wb_cycle) begin
                inflight = 1'b0;
            end
            if (exp_ready && start && !flush) begin
                if (op <= OP_DIV) begin
                    m_a = a;
                    m_b = b;
                    m_op = op;
                    m_dbl = double;
                    m_rd = rd;
                    wb_cycle = cyc + lat_of(op) + 1;
                    inflight = 1'b1;
                end else begin
                    illegal_cycle = cyc + 1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic d,
                         input logic [63:0] x, input logic [63:0] y, input logic [4:0] r,
                         input logic f);
        start = s;
        op = o;
        double = d;
        a = x;
        b = y;
        rd = r;
        flush = f;
    endtask

    logic [63:0] div_res;

    initial begin
        model_reset();
        div_res = $realtobits(3.0);

        // Reset values
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        chk("reset_result", result, 64'd0);

        // Single-precision add 1.0 + 2.0
        drive(1'b1, OP_ADD, 1'b0, 64'h3F80_0000, 64'h4000_0000, 5'd5, 1'b0);
        cycle();
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (3) cycle();
        chk("add_result", result, 64'h0000_0000_4040_0000);

        // Subtract 3.0 - 1.0, second op issued in the DONE cycle
        drive(1'b1, OP_SUB, 1'b0, 64'h4040_0000, 64'h3F80_0000, 5'd6, 1'b0);
        cycle();
        drive(1'b1, OP_ADD, 1'b0, 64'h3F80_0000, 64'h3F80_0000, 5'd7, 1'b0);
        cycle();
        chk("sub_result", result, 64'h0000_0000_4000_0000);
        chk("sub_wr_rd", 64'(wr_rd), 64'd6);
        cycle();
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (3) cycle();

        // Double-precision divide 7.5 / 2.5 with toggling inputs during EXEC
        drive(1'b1, OP_DIV, 1'b1, $realtobits(7.5), $realtobits(2.5), 5'd9, 1'b0);
        cycle();
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 3'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom), 1'b0);
            cycle();
        end
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        cycle();
        chk("div_result", result, div_res);
        cycle();

        // Multiply flushed in its second EXEC cycle
        drive(1'b1, OP_MUL, 1'b1, $realtobits(2.0), $realtobits(4.0), 5'd10, 1'b0);
        cycle();
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (5) cycle();
        chk("flush_result", result, div_res);

        // Undefined opcode in IDLE
        drive(1'b1, 3'b111, 1'b0, 64'd1, 64'd2, 5'd3, 1'b0);
        cycle();
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (3) cycle();

        // Asynchronous reset in the middle of a divide
        drive(1'b1, OP_DIV, 1'b1, $realtobits(9.0), $realtobits(3.0), 5'd12, 1'b0);
        cycle();
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (4) cycle();
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_fpu_a", fpu_a, 64'd0);
        model_reset();
        repeat (2) cycle();
        #2 reset = 1'b0;
        repeat (16) cycle();

        // Random traffic, including undefined opcodes and flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7)),
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                  1'($urandom_range(0, 15) == 0));
            cycle();
        end
        drive(1'b0, OP_ADD, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
